obuft_serial_driver: RTL

//   Upstream driver stage for a tri-state output pad buffer (OBUFT-class cell: O = T ? Z : I).

---
 rtl/obuft_serial_driver.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/obuft_serial_driver.sv
// obuft_serial_driver
//   Upstream driver stage for a tri-state output pad buffer (O = T ? Z : I).
//   Accepts parallel words on a valid/ready handshake and shifts them out MSB-first
//   on buf_i. It controls buf_t so that the pad is released while idle. Each burst is
//   wrapped in lead-in and tail guard periods, during which the pad is driven at IDLE_LEVEL.
//   Global tri-state override is left to the pad buffer itself.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   data   in   WIDTH  word to transmit, captured when valid & ready
//   valid  in   1      data is valid
//   ready  out  1      word can be accepted this cycle (combinational from state/counter)
//   buf_i  out  1      to pad buffer I input (registered)
//   buf_t  out  1      to pad buffer T input, 1 releases the pad (registered)
//   busy   out  1      state is not IDLE (registered)
module obuft_serial_driver #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned LEAD       = 2,
    parameter int unsigned TAIL       = 1,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             buf_i,
    output logic             buf_t,
    output logic             busy
);

    localparam int unsigned CNT_W = 5;

    // Counter load values: the counter holds the number of cycles left in the state, minus one.
    localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LEAD_LOAD  = CNT_W'((LEAD > 0) ? (LEAD - 1) : 0);
    localparam logic [CNT_W-1:0] TAIL_LOAD  = CNT_W'((TAIL > 0) ? (TAIL - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_TAIL  = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic             buf_i_d, buf_t_d, busy_d;
    logic             accept;

    // Ready windows: idle, the last data bit (for gapless chaining), and the tail guard.
    always_comb begin
        ready = 1'b0;
        case (state)
            ST_IDLE:  ready = 1'b1;
            ST_SHIFT: ready = (cnt == '0);
            ST_TAIL:  ready = 1'b1;
            default:  ready = 1'b0;
        endcase
    end

    assign accept = valid & ready;

    // State and datapath registers. Reset releases the pad immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            shreg <= '0;
            buf_i <= IDLE_LEVEL;
            buf_t <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            shreg <= shreg_d;
            buf_i <= buf_i_d;
            buf_t <= buf_t_d;
            busy  <= busy_d;
        end
    end

    // Next state and counter: the counter loads on state entry and counts down to zero.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (LEAD > 0) begin
                        state_d = ST_LEAD;
                        cnt_d   = LEAD_LOAD;
                    end else begin
                        state_d = ST_SHIFT;
                        cnt_d   = SHIFT_LOAD;
                    end
                end
            end
            ST_LEAD: begin
                if (cnt == '0) begin
                    state_d = ST_SHIFT;
                    cnt_d   = SHIFT_LOAD;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt == '0) begin
                    if (accept) begin
                        state_d = ST_SHIFT;
                        cnt_d   = SHIFT_LOAD;
                    end else if (TAIL > 0) begin
                        state_d = ST_TAIL;
                        cnt_d   = TAIL_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_TAIL: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    cnt_d   = SHIFT_LOAD;
                end else if (cnt == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next register values for the outputs. These are aligned with state_d, so buf_t rises
    // on the very edge that enters IDLE. buf_i falls back to IDLE_LEVEL on that same edge.
    always_comb begin
        shreg_d = shreg;
        buf_i_d = IDLE_LEVEL;
        buf_t_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        if (accept) begin
            if (state_d == ST_SHIFT) begin
                // Straight into data: drive the MSB now and keep the remaining bits.
                buf_i_d = data[WIDTH-1];
                shreg_d = {data[WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = data;
            end
        end else if (state_d == ST_SHIFT) begin
            buf_i_d = shreg[WIDTH-1];
            shreg_d = {shreg[WIDTH-2:0], 1'b0};
        end
    end

endmodule
